// File: rtl/led_panel_pkg.sv
// LED panel geometry, scan FSM states and colour layout
// shared by the HUB75 scan driver and its BCM timer.
package led_panel_pkg;

  localparam int PANEL_W   = 64;
  localparam int PANEL_H   = 64;
  localparam int SCAN_ROWS = 32;
  localparam int PLANES    = 4;

  localparam int COL_W   = $clog2(PANEL_W);
  localparam int ROW_W   = $clog2(SCAN_ROWS);
  localparam int PLANE_W = $clog2(PLANES);
  localparam int ADDR_W  = 1 + ROW_W + COL_W;
  localparam int PIX_W   = 24;

  localparam int R_LSB = 20;
  localparam int G_LSB = 12;
  localparam int B_LSB = 4;
  localparam int NIB_W = 4;

  localparam int BCM_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_TOP,
    FETCH_BOT,
    DRIVE,
    CLK_HIGH,
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_t;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-code-modulation on-time counter: after a start
// pulse, done rises on the last of BASE_TICKS<<plane cycles.
module hub75_bcm_timer
  import led_panel_pkg::*;
#(
  parameter int BASE_TICKS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PLANE_W-1:0] plane,
  output logic               done
);

  logic [BCM_CNT_W-1:0] r_cnt;
  logic                 r_busy;
  logic [BCM_CNT_W-1:0] w_load;

  assign w_load = (BCM_CNT_W'(BASE_TICKS) << plane)
                - BCM_CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_cnt  <= w_load;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign done = r_busy && (r_cnt == '0);

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 1/32-scan driver: shifts 64 columns per plane,
// latches, then shows each of 4 BCM planes per row.
module hub75_scan_driver
  import led_panel_pkg::*;
#(
  parameter int BASE_TICKS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [PIX_W-1:0]  pixel_data,
  output logic              panel_r1,
  output logic              panel_g1,
  output logic              panel_b1,
  output logic              panel_r2,
  output logic              panel_g2,
  output logic              panel_b2,
  output logic              panel_clk,
  output logic              panel_lat,
  output logic              panel_oe_n,
  output logic [ROW_W-1:0]  panel_row,
  output logic              frame_start
);

  scan_state_t        r_state;
  scan_state_t        w_next;
  logic [ROW_W-1:0]   r_row;
  logic [PLANE_W-1:0] r_plane;
  logic [COL_W-1:0]   r_col;
  rgb_t               r_top;
  rgb_t               r_c1;
  rgb_t               r_c2;
  rgb_t               w_px;
  logic [NIB_W-1:0]   w_rn;
  logic [NIB_W-1:0]   w_gn;
  logic [NIB_W-1:0]   w_bn;
  logic               w_unused_px;
  logic               w_done;
  logic               w_start;
  logic               w_last_col;
  logic               w_last_plane;

  assign w_rn = pixel_data[R_LSB +: NIB_W];
  assign w_gn = pixel_data[G_LSB +: NIB_W];
  assign w_bn = pixel_data[B_LSB +: NIB_W];
  assign w_unused_px = ^{pixel_data[19:16],
                         pixel_data[11:8],
                         pixel_data[3:0]};

  assign w_px = '{r: w_rn[r_plane],
                  g: w_gn[r_plane],
                  b: w_bn[r_plane]};

  assign w_last_col   = (r_col == COL_W'(PANEL_W - 1));
  assign w_last_plane = (r_plane == PLANE_W'(PLANES - 1));

  hub75_bcm_timer #(
    .BASE_TICKS(BASE_TICKS)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(w_start),
    .plane(r_plane),
    .done (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (enable) w_next = FETCH_TOP;
      FETCH_TOP: w_next = FETCH_BOT;
      FETCH_BOT: w_next = DRIVE;
      DRIVE:     w_next = CLK_HIGH;
      CLK_HIGH:  w_next = w_last_col ? BLANK : FETCH_TOP;
      BLANK:     w_next = LATCH;
      LATCH:     w_next = DISPLAY;
      DISPLAY:
        if (w_done) w_next = enable ? FETCH_TOP : IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    panel_oe_n  = 1'b1;
    panel_clk   = 1'b0;
    panel_lat   = 1'b0;
    frame_start = 1'b0;
    w_start     = 1'b0;
    pixel_addr  = {1'b0, r_row, r_col};
    unique case (r_state)
      FETCH_TOP:
        frame_start = (r_row == '0) && (r_plane == '0)
                   && (r_col == '0);
      FETCH_BOT: pixel_addr = {1'b1, r_row, r_col};
      CLK_HIGH:  panel_clk = 1'b1;
      LATCH: begin
        panel_lat = 1'b1;
        w_start   = 1'b1;
      end
      DISPLAY:   panel_oe_n = 1'b0;
      default: ;
    endcase
  end

  // Colour pins load on the edge into DRIVE, so they are
  // settled a full cycle before panel_clk rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row     <= '0;
      r_plane   <= '0;
      r_col     <= '0;
      r_top     <= '0;
      r_c1      <= '0;
      r_c2      <= '0;
      panel_row <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_row   <= '0;
          r_plane <= '0;
          r_col   <= '0;
        end
        FETCH_TOP: r_top <= w_px;
        FETCH_BOT: begin
          r_c1 <= r_top;
          r_c2 <= w_px;
        end
        CLK_HIGH: r_col <= r_col + 1'b1;
        BLANK:    panel_row <= r_row;
        DISPLAY:
          if (w_done) begin
            r_col <= '0;
            if (!enable) begin
              r_row   <= '0;
              r_plane <= '0;
            end else if (w_last_plane) begin
              r_plane <= '0;
              r_row   <= r_row + 1'b1;
            end else begin
              r_plane <= r_plane + 1'b1;
            end
          end
        default: ;
      endcase
    end
  end

  assign panel_r1 = r_c1.r;
  assign panel_g1 = r_c1.g;
  assign panel_b1 = r_c1.b;
  assign panel_r2 = r_c2.r;
  assign panel_g2 = r_c2.g;
  assign panel_b2 = r_c2.b;

endmodule
